// File: rtl/pwls_seq_pkg.sv
// Shared encodings for the PWL bus sequencer: command ops, bus strobe codes,
// sequencer states and the packed command FIFO entry.
package pwls_seq_pkg;

  localparam logic [1:0] OP_WRITE16 = 2'd0;
  localparam logic [1:0] OP_WRITE32 = 2'd1;
  localparam logic [1:0] OP_READ16  = 2'd2;
  localparam logic [1:0] OP_WAIT    = 2'd3;

  localparam logic [1:0] BUS_IDLE = 2'b11;
  localparam logic [1:0] WIDTH16  = 2'b01;
  localparam logic [1:0] WIDTH32  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ_WAIT,
    ST_READ_GAP,
    ST_DELAY
  } seq_state_e;

  typedef struct packed {
    logic [1:0]  op;
    logic [5:0]  addr;
    logic [31:0] data;
  } cmd_entry_t;

endpackage

// File: rtl/pwls_cmd_fifo.sv
// Synchronous command FIFO; the head entry is read straight from the storage
// registers so the sequencer can pop and launch a bus cycle on the same edge.
module pwls_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 40
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Pointers carry one extra bit so full and empty are distinguishable.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push && !full) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop && !empty) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  assign count   = wr_ptr_q - rd_ptr_q;
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/pwls_bus_sequencer.sv
// Plays queued write/read/wait commands onto the TinyQV peripheral register
// bus, one transaction at a time, with registered bus outputs.
module pwls_bus_sequencer
  import pwls_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [5:0]                   cmd_addr,
  input  logic [31:0]                  cmd_data,
  output logic [5:0]                   address,
  output logic [31:0]                  data_in,
  output logic [1:0]                   data_write_n,
  output logic [1:0]                   data_read_n,
  input  logic [31:0]                  data_out,
  input  logic                         data_ready,
  output logic                         rsp_valid,
  output logic [31:0]                  rsp_data,
  output logic                         rsp_timeout,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  seq_state_e  state_q;
  logic [5:0]  address_q;
  logic [31:0] data_in_q;
  logic [1:0]  write_n_q;
  logic [1:0]  read_n_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_data_q;
  logic        rsp_timeout_q;
  logic [15:0] cnt_q;

  logic        fifo_full;
  logic        fifo_empty;
  logic [39:0] fifo_rd_data;
  cmd_entry_t  head;
  logic        step_done;
  logic        pop;

  pwls_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (40)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (cmd_valid && cmd_ready),
    .pop     (pop),
    .wr_data ({cmd_op, cmd_addr, cmd_data}),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign head      = cmd_entry_t'(fifo_rd_data);
  assign cmd_ready = !fifo_full;

  // States that end on this edge hand over to the next queued command directly.
  assign step_done = (state_q == ST_IDLE) || (state_q == ST_WRITE) ||
                     (state_q == ST_READ_GAP) ||
                     ((state_q == ST_DELAY) && (cnt_q == 16'd0));
  assign pop       = step_done && !fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      address_q     <= '0;
      data_in_q     <= '0;
      write_n_q     <= BUS_IDLE;
      read_n_q      <= BUS_IDLE;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_READ_WAIT: begin
          if (data_ready) begin
            rsp_valid_q   <= 1'b1;
            rsp_data_q    <= data_out;
            rsp_timeout_q <= 1'b0;
            read_n_q      <= BUS_IDLE;
            address_q     <= '0;
            state_q       <= ST_READ_GAP;
          end else if (cnt_q == TIMEOUT_LAST) begin
            rsp_valid_q   <= 1'b1;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b1;
            read_n_q      <= BUS_IDLE;
            address_q     <= '0;
            state_q       <= ST_READ_GAP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ST_DELAY: begin
          if (cnt_q != 16'd0) cnt_q <= cnt_q - 16'd1;
        end
        default: ;
      endcase

      if (step_done) begin
        address_q <= '0;
        data_in_q <= '0;
        write_n_q <= BUS_IDLE;
        read_n_q  <= BUS_IDLE;
        cnt_q     <= '0;
        state_q   <= ST_IDLE;
        if (pop) begin
          case (head.op)
            OP_WRITE16: begin
              address_q <= head.addr;
              data_in_q <= head.data;
              write_n_q <= WIDTH16;
              state_q   <= ST_WRITE;
            end
            OP_WRITE32: begin
              address_q <= head.addr;
              data_in_q <= head.data;
              write_n_q <= WIDTH32;
              state_q   <= ST_WRITE;
            end
            OP_READ16: begin
              address_q <= head.addr;
              read_n_q  <= WIDTH16;
              state_q   <= ST_READ_WAIT;
            end
            default: begin
              // Delay counter holds the remaining idle cycles minus one.
              cnt_q   <= (head.data[15:0] == 16'd0) ? 16'd0 : head.data[15:0] - 16'd1;
              state_q <= ST_DELAY;
            end
          endcase
        end
      end
    end
  end

  assign address      = address_q;
  assign data_in      = data_in_q;
  assign data_write_n = write_n_q;
  assign data_read_n  = read_n_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_timeout  = rsp_timeout_q;
  assign busy         = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_pwls_bus_sequencer.sv
// Directed bench for pwls_bus_sequencer with a small synth-peripheral model
// that returns data_ready one cycle after a read is seen.
module tb_pwls_bus_sequencer;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_timeout;
  logic        busy;
  logic [3:0]  fifo_count;

  int assertCount = 0;
  int failCount   = 0;

  logic synthMode = 1'b0;
  logic readEnQ   = 1'b0;
  int   rspCount  = 0;
  int   cycleNo   = 0;
  int   writeCycle[$];
  int   writeAddr[$];

  pwls_bus_sequencer #(
    .FIFO_DEPTH (8),
    .TIMEOUT    (15)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_addr     (cmd_addr),
    .cmd_data     (cmd_data),
    .address      (address),
    .data_in      (data_in),
    .data_write_n (data_write_n),
    .data_read_n  (data_read_n),
    .data_out     (data_out),
    .data_ready   (data_ready),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_timeout  (rsp_timeout),
    .busy         (busy),
    .fifo_count   (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Peripheral model: registered read enable gives ready one cycle late plus one trailing cycle.
  always @(posedge clk) readEnQ <= synthMode && (data_read_n == 2'b01);
  assign data_ready = readEnQ;
  assign data_out   = 32'h0000_BEEF;

  always @(posedge clk) begin
    if (rsp_valid) rspCount++;
    if (data_write_n != 2'b11) begin
      writeCycle.push_back(cycleNo);
      writeAddr.push_back(int'(address));
    end
    cycleNo++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [5:0] addr, input logic [31:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int waited;
    int held;
    int base;
    int rspBase;
    int gap1;
    int gap2;

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_addr  = 6'd0;
    cmd_data  = 32'd0;
    idleCycles(3);
    reset = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_write_n", 32'(data_write_n), 32'h3);
    checkOutput("rst_read_n", 32'(data_read_n), 32'h3);
    checkOutput("rst_address", 32'(address), 32'h0);
    checkOutput("rst_data_in", data_in, 32'h0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("rst_rsp_data", rsp_data, 32'h0);
    checkOutput("rst_rsp_timeout", 32'(rsp_timeout), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_count", 32'(fifo_count), 32'h0);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'h1);

    $display("[TB] single WRITE16");
    applyStimulus(2'd0, 6'h04, 32'h0000_1234);
    checkOutput("w16_count_after_push", 32'(fifo_count), 32'h1);
    checkOutput("w16_busy_after_push", 32'(busy), 32'h1);
    checkOutput("w16_not_yet", 32'(data_write_n), 32'h3);
    @(negedge clk);
    checkOutput("w16_write_n", 32'(data_write_n), 32'h1);
    checkOutput("w16_address", 32'(address), 32'h4);
    checkOutput("w16_data_in", data_in, 32'h0000_1234);
    checkOutput("w16_busy_during", 32'(busy), 32'h1);
    @(negedge clk);
    checkOutput("w16_released", 32'(data_write_n), 32'h3);
    checkOutput("w16_addr_idle", 32'(address), 32'h0);
    checkOutput("w16_busy_fall", 32'(busy), 32'h0);

    $display("[TB] FIFO fill behind DELAY 100");
    cmd_valid = 1'b1;
    cmd_op    = 2'd3;
    cmd_addr  = 6'd0;
    cmd_data  = 32'd100;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      cmd_op   = 2'd1;
      cmd_addr = 6'(i);
      cmd_data = 32'hA000_0000 + 32'(i);
      @(negedge clk);
    end
    checkOutput("fill_count", 32'(fifo_count), 32'h8);
    checkOutput("fill_cmd_ready", 32'(cmd_ready), 32'h0);
    cmd_addr = 6'h3F;
    cmd_data = 32'hDEAD_DEAD;
    idleCycles(2);
    cmd_valid = 1'b0;
    checkOutput("ninth_rejected_count", 32'(fifo_count), 32'h8);
    checkOutput("stalled_bus_idle", 32'(data_write_n), 32'h3);
    waited = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      waited++;
      if (data_write_n != 2'b11) break;
    end
    checkOutput("delay100_latency", 32'(waited), 32'd91);
    for (int i = 0; i < 8; i++) begin
      if (i != 0) @(negedge clk);
      checkOutput($sformatf("burst_write_n_%0d", i), 32'(data_write_n), 32'h2);
      checkOutput($sformatf("burst_addr_%0d", i), 32'(address), 32'(i));
      checkOutput($sformatf("burst_data_%0d", i), data_in, 32'hA000_0000 + 32'(i));
    end
    @(negedge clk);
    checkOutput("burst_end_idle", 32'(data_write_n), 32'h3);
    checkOutput("burst_end_busy", 32'(busy), 32'h0);

    $display("[TB] READ16 against synth model");
    synthMode = 1'b1;
    rspBase   = rspCount;
    applyStimulus(2'd2, 6'h02, 32'h0);
    @(negedge clk);
    checkOutput("rd_read_n", 32'(data_read_n), 32'h1);
    checkOutput("rd_address", 32'(address), 32'h2);
    @(negedge clk);
    checkOutput("rd_held_2nd", 32'(data_read_n), 32'h1);
    checkOutput("rd_no_rsp_yet", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    checkOutput("rd_rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("rd_rsp_data", rsp_data, 32'h0000_BEEF);
    checkOutput("rd_rsp_timeout", 32'(rsp_timeout), 32'h0);
    checkOutput("rd_released", 32'(data_read_n), 32'h3);
    checkOutput("rd_trailing_ready", 32'(data_ready), 32'h1);
    @(negedge clk);
    checkOutput("rd_rsp_pulse_end", 32'(rsp_valid), 32'h0);
    idleCycles(5);
    checkOutput("rd_single_rsp", 32'(rspCount - rspBase), 32'h1);
    checkOutput("rd_busy_done", 32'(busy), 32'h0);

    $display("[TB] READ16 timeout");
    synthMode = 1'b0;
    applyStimulus(2'd2, 6'h03, 32'h0);
    held = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (data_read_n == 2'b01) held++;
      else break;
    end
    checkOutput("to_held_cycles", 32'(held), 32'd15);
    checkOutput("to_rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("to_rsp_timeout", 32'(rsp_timeout), 32'h1);
    checkOutput("to_rsp_data", rsp_data, 32'h0);
    idleCycles(3);

    $display("[TB] WAIT 0 and WAIT 5 between writes");
    base      = writeCycle.size();
    cmd_valid = 1'b1;
    cmd_op = 2'd0; cmd_addr = 6'd1; cmd_data = 32'h11; @(negedge clk);
    cmd_op = 2'd3; cmd_addr = 6'd0; cmd_data = 32'd0;  @(negedge clk);
    cmd_op = 2'd0; cmd_addr = 6'd2; cmd_data = 32'h22; @(negedge clk);
    cmd_op = 2'd3; cmd_addr = 6'd0; cmd_data = 32'd5;  @(negedge clk);
    cmd_op = 2'd0; cmd_addr = 6'd3; cmd_data = 32'h33; @(negedge clk);
    cmd_valid = 1'b0;
    idleCycles(15);
    checkOutput("wait_write_count", 32'(writeCycle.size() - base), 32'd3);
    gap1 = -1;
    gap2 = -1;
    if (writeCycle.size() - base >= 3) begin
      gap1 = writeCycle[base + 1] - writeCycle[base] - 1;
      gap2 = writeCycle[base + 2] - writeCycle[base + 1] - 1;
      checkOutput("wait_order_last", 32'(writeAddr[base + 2]), 32'd3);
    end
    checkOutput("wait0_gap", 32'(gap1), 32'd1);
    checkOutput("wait5_gap", 32'(gap2), 32'd5);

    $display("[TB] reset during READ_WAIT");
    rspBase   = rspCount;
    base      = writeCycle.size();
    cmd_valid = 1'b1;
    cmd_op = 2'd2; cmd_addr = 6'd5; cmd_data = 32'h0; @(negedge clk);
    cmd_op = 2'd0; cmd_addr = 6'd6; cmd_data = 32'h66; @(negedge clk);
    cmd_op = 2'd0; cmd_addr = 6'd7; cmd_data = 32'h77; @(negedge clk);
    cmd_op = 2'd0; cmd_addr = 6'd8; cmd_data = 32'h88; @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("abort_pre_read_n", 32'(data_read_n), 32'h1);
    checkOutput("abort_pre_count", 32'(fifo_count), 32'h3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_read_n", 32'(data_read_n), 32'h3);
    checkOutput("abort_address", 32'(address), 32'h0);
    checkOutput("abort_count", 32'(fifo_count), 32'h0);
    checkOutput("abort_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("abort_busy", 32'(busy), 32'h0);
    checkOutput("abort_cmd_ready", 32'(cmd_ready), 32'h1);
    idleCycles(20);
    checkOutput("abort_no_rsp", 32'(rspCount - rspBase), 32'h0);
    checkOutput("abort_no_writes", 32'(writeCycle.size() - base), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
